// File: rtl/cpu_result_fifo.sv
// Write-back merge buffer: one FIFO per result producer, round-robin drained
// into a single registered write-back slot.
module cpu_result_fifo #(
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 9,
  parameter int REG_BITS   = 5,
  parameter int AF_MARGIN  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]   src_tag,
  output logic [NUM_SRC-1:0]             src_almost_full,
  output logic [NUM_SRC-1:0]             src_overflow,
  input  logic                           cpu_ready,
  output logic                           read_valid,
  output logic [REG_BITS-1:0]            read_dest_reg,
  output logic [DATA_WIDTH-1:0]          read_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]    nonempty;
  logic [NUM_SRC-1:0]    pop;
  logic [REG_BITS-1:0]   head_dest [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         grant_idx;
  logic                  grant_found;
  logic                  load;
  logic                  unused_tag_bits;

  // Only the low REG_BITS of each tag name the destination register.
  assign unused_tag_bits = ^src_tag;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return GW'(s);
  endfunction

  // First non-empty channel after the last one granted, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!grant_found && nonempty[wrap_idx(last_grant, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(last_grant, k);
      end
    end
  end

  assign load = (!read_valid || cpu_ready) && grant_found;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    logic [REG_BITS-1:0]   dest;
    logic                  push_req;
    logic                  push_ok;
    logic                  full;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  af_q;
    logic                  ovf_q;
    logic [REG_BITS-1:0]   mem_dest [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    assign dest     = src_tag[i*TAG_WIDTH +: REG_BITS];
    assign push_req = src_valid[i] && (dest != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop[i]   = load && (grant_idx == GW'(i));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop[i]);

    assign nonempty[i]        = (count != '0);
    assign head_dest[i]       = mem_dest[rd_ptr];
    assign head_data[i]       = mem_data[rd_ptr];
    assign src_almost_full[i] = af_q;
    assign src_overflow[i]    = ovf_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        af_q   <= (DEPTH <= AF_MARGIN);
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop[i])      count <= count + 1'b1;
        else if (!push_ok && pop[i]) count <= count - 1'b1;
        af_q <= ((DEPTH - int'(count)) <= AF_MARGIN);
        if (push_req && full && !pop[i]) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (push_ok) begin
        mem_dest[wr_ptr] <= dest;
        mem_data[wr_ptr] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_valid    <= 1'b0;
      read_dest_reg <= '0;
      read_data     <= '0;
      last_grant    <= GW'(NUM_SRC - 1);
    end else if (load) begin
      read_valid    <= 1'b1;
      read_dest_reg <= head_dest[grant_idx];
      read_data     <= head_data[grant_idx];
      last_grant    <= grant_idx;
    end else if (cpu_ready) begin
      read_valid    <= 1'b0;
      read_dest_reg <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_result_fifo.sv
// Scoreboard bench for cpu_result_fifo: queue-based reference model predicts
// each write-back entry; a negedge monitor consumes and compares them.
module tb_cpu_result_fifo;

  localparam int NS  = 3;
  localparam int D   = 4;
  localparam int DW  = 32;
  localparam int TW  = 9;
  localparam int RB  = 5;
  localparam int AFM = 2;
  localparam int E   = RB + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_data;
  logic [NS*TW-1:0]  src_tag;
  logic [NS-1:0]     src_almost_full;
  logic [NS-1:0]     src_overflow;
  logic              cpu_ready;
  logic              read_valid;
  logic [RB-1:0]     read_dest_reg;
  logic [DW-1:0]     read_data;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [E-1:0] mq [NS][$];
  logic [E-1:0] exp_q [$];
  int           m_last;
  bit           cur_valid, nxt_valid;
  logic [NS-1:0] cur_af, nxt_af, cur_ovf, nxt_ovf;

  cpu_result_fifo #(
    .NUM_SRC(NS), .DEPTH(D), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .REG_BITS(RB), .AF_MARGIN(AFM)
  ) dut (
    .clock(clk), .reset(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_tag(src_tag),
    .src_almost_full(src_almost_full), .src_overflow(src_overflow),
    .cpu_ready(cpu_ready), .read_valid(read_valid),
    .read_dest_reg(read_dest_reg), .read_data(read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    exp_q.delete();
    m_last    = NS - 1;
    cur_valid = 1'b0;
    nxt_valid = 1'b0;
    cur_af    = {NS{1'b0}};
    nxt_af    = {NS{1'b0}};
    cur_ovf   = '0;
    nxt_ovf   = '0;
  endtask

  // Effect of the coming clock edge, from the buffer rules applied to queues.
  task automatic predict();
    int   sz_before [NS];
    bit   popped [NS];
    bit   any;
    int   g;
    logic [E-1:0] ent;
    logic [RB-1:0] dst;
    any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sz_before[i] = mq[i].size();
      popped[i]    = 1'b0;
      if (sz_before[i] > 0) any = 1'b1;
    end
    nxt_valid = cur_valid;
    nxt_ovf   = cur_ovf;
    if ((!cur_valid || cpu_ready) && any) begin
      g = -1;
      for (int k = 1; k <= NS; k++) begin
        int c = (m_last + k) % NS;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      ent = mq[g].pop_front();
      exp_q.push_back(ent);
      popped[g] = 1'b1;
      m_last    = g;
      nxt_valid = 1'b1;
    end else if (cpu_ready) begin
      nxt_valid = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      dst = src_tag[i*TW +: RB];
      if (src_valid[i] && dst != 0) begin
        if (mq[i].size() < D) mq[i].push_back({dst, src_data[i*DW +: DW]});
        else nxt_ovf[i] = 1'b1;
      end
      nxt_af[i] = ((D - sz_before[i]) <= AFM);
    end
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    cur_valid = nxt_valid;
    cur_af    = nxt_af;
    cur_ovf   = nxt_ovf;
    #1;
  endtask

  task automatic set_push(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] dat);
    src_valid[ch]         = 1'b1;
    src_tag[ch*TW +: TW]  = tag;
    src_data[ch*DW +: DW] = dat;
  endtask

  function automatic bit model_busy();
    bit b = cur_valid;
    for (int i = 0; i < NS; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    src_valid = '0;
    cpu_ready = 1'b1;
    while (model_busy() && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d cycles required < 64", n);
    end
    chk("sb_leftover", exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [E-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1) begin
        chk("read_valid", read_valid, cur_valid);
        if (read_valid && cpu_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_extra: got dest %0d data %h required no entry", read_dest_reg, read_data);
          end else begin
            e = exp_q.pop_front();
            chk("read_entry", {read_dest_reg, read_data}, e);
          end
        end
        if (!read_valid) chk("dest_idle_zero", read_dest_reg, 0);
        chk("almost_full", src_almost_full, cur_af);
        chk("overflow", src_overflow, cur_ovf);
      end
    end
  end

  initial begin
    logic [TW-1:0] tag;
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    src_tag   = '0;
    cpu_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", read_valid, 0);
    chk("rst_dest", read_dest_reg, 0);
    chk("rst_data", read_data, 0);
    chk("rst_af", src_almost_full, 0);
    chk("rst_ovf", src_overflow, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Round-robin: two identical bursts both drain as 1, 2, 3.
    cpu_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_push(0, 9'h001, 32'hA0 + b);
      set_push(1, 9'h002, 32'hB0 + b);
      set_push(2, 9'h003, 32'hC0 + b);
      step();
      src_valid = '0;
      for (int k = 1; k <= 3; k++) begin
        step();
        chk("rr_valid", read_valid, 1);
        chk("rr_dest", read_dest_reg, k);
      end
      step();
      chk("rr_idle", read_valid, 0);
    end

    // Single push latency.
    set_push(0, 9'h005, 32'hDEADBEEF);
    step();
    src_valid = '0;
    chk("lat_n1", read_valid, 0);
    step();
    chk("lat_n2_valid", read_valid, 1);
    chk("lat_n2_dest", read_dest_reg, 5);
    chk("lat_n2_data", read_data, 32'hDEADBEEF);
    step();
    chk("lat_n3", read_valid, 0);

    // Backpressure and overflow on channel 1 behind a held output entry.
    cpu_ready = 1'b0;
    set_push(0, 9'h007, 32'h77);
    step();
    src_valid = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      set_push(1, TW'(8 + k), 32'h100 + k);
      step();
      if (k == 1) chk("af_after_push2", src_almost_full[1], 0);
      if (k == 2) chk("af_cycle_later", src_almost_full[1], 1);
      if (k == 3) chk("ovf_before_5th", src_overflow[1], 0);
      if (k == 4) chk("ovf_on_5th", src_overflow[1], 1);
    end
    drain();
    chk("ovf_sticky", src_overflow[1], 1);

    // Dest-zero entries vanish.
    set_push(2, 9'h100, 32'h12345678);
    step();
    src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zero_reg_no_out", read_valid, 0);
    end
    chk("zero_reg_no_ovf", src_overflow[2], 0);

    // Full FIFO accepts a push while its head is popped.
    cpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_push(0, TW'(8'h11 + k), 32'h200 + k);
      step();
    end
    chk("full_no_ovf", src_overflow[0], 0);
    cpu_ready = 1'b1;
    set_push(0, 9'h016, 32'h205);
    step();
    chk("full_pop_push_ovf", src_overflow[0], 0);
    drain();

    // Randomised traffic with stalls.
    for (int n = 0; n < 3000; n++) begin
      src_valid = '0;
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          tag = TW'($urandom_range(0, 511));
          if ($urandom_range(0, 7) == 0) tag[RB-1:0] = '0;
          set_push(i, tag, $urandom);
        end
      end
      cpu_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

    // Reset in the middle of a burst.
    cpu_ready = 1'b0;
    set_push(0, 9'h00A, 32'hAA);
    set_push(1, 9'h00B, 32'hBB);
    set_push(2, 9'h00C, 32'hCC);
    step();
    src_valid = '0;
    step();
    set_push(0, 9'h00D, 32'hDD);
    step();
    src_valid = '0;
    chk("pre_reset_valid", read_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", read_valid, 0);
    chk("reset_async_dest", read_dest_reg, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cpu_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_reset_idle", read_valid, 0);
    end
    chk("post_reset_ovf", src_overflow, 0);
    chk("sb_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
